// File: rtl/write_back_queue.sv
// In-order write-back collector: round-robin accepts execute results into a FIFO and drains one
// register-file write per cycle. Optional same-edge bypass into the output register: WB_BYPASS_EN.
module write_back_queue #(
    parameter int N_SRC         = 2,
    parameter int DEPTH         = 8,
    parameter int LEN_WORD      = 32,
    parameter int LEN_PREG_ADDR = 6,
    parameter int LEN_CONTEXT   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_SRC-1:0]                src_valid,
    output logic [N_SRC-1:0]                src_ready,
    input  logic [N_SRC*LEN_PREG_ADDR-1:0]  src_rd,
    input  logic [N_SRC*LEN_WORD-1:0]       src_data,
    input  logic [N_SRC*LEN_CONTEXT-1:0]    src_ctx,
    input  logic                            branch_hazard,
    input  logic [LEN_CONTEXT-1:0]          hazard_context_info,
    output logic                            w_order,
    output logic [LEN_PREG_ADDR-1:0]        w_pa_rd,
    output logic [LEN_WORD-1:0]             w_d_rd,
    output logic [$clog2(DEPTH):0]          pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [LEN_PREG_ADDR-1:0] in_rd   [N_SRC];
    logic [LEN_WORD-1:0]      in_data [N_SRC];
    logic [LEN_CONTEXT-1:0]   in_ctx  [N_SRC];
    logic [N_SRC-1:0]         in_kill;

    logic [LEN_PREG_ADDR-1:0] rd_mem   [DEPTH];
    logic [LEN_WORD-1:0]      data_mem [DEPTH];
    logic [LEN_CONTEXT-1:0]   ctx_mem  [DEPTH];
    logic [DEPTH-1:0]         kill_reg;
    logic [DEPTH-1:0]         squash_hit;

    logic [AW-1:0] head_reg, tail_reg;
    logic [CW-1:0] count_reg;
    logic [RW-1:0] rr_reg;

    logic [CW-1:0] free;
    logic [N_SRC-1:0] grant;
    logic [RW-1:0] push_src [N_SRC];
    logic [RW-1:0] byp_src;
    logic [CW-1:0] n_push;
    logic [RW-1:0] rr_next;
    logic          byp;
    logic          pop;
    logic          byp_allowed;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            assign in_rd[gi]   = src_rd[gi*LEN_PREG_ADDR +: LEN_PREG_ADDR];
            assign in_data[gi] = src_data[gi*LEN_WORD +: LEN_WORD];
            assign in_ctx[gi]  = src_ctx[gi*LEN_CONTEXT +: LEN_CONTEXT];
            assign in_kill[gi] = branch_hazard && ((in_ctx[gi] & hazard_context_info) != '0);
        end
        for (gi = 0; gi < DEPTH; gi++) begin : g_squash
            assign squash_hit[gi] = branch_hazard && ((ctx_mem[gi] & hazard_context_info) != '0);
        end
    endgenerate

    assign pop = (count_reg != '0);
`ifdef WB_BYPASS_EN
    assign byp_allowed = (count_reg == '0);
`else
    assign byp_allowed = 1'b0;
`endif

    // The head leaves every cycle, so its slot is reusable by this edge's pushes.
    assign free = CW'(DEPTH) - count_reg + CW'(pop);

    always_comb begin
        int idx;
        int n_acc;
        int n_p;
        idx     = 0;
        n_acc   = 0;
        n_p     = 0;
        grant   = '0;
        byp     = 1'b0;
        byp_src = '0;
        rr_next = rr_reg;
        for (int k = 0; k < N_SRC; k++) push_src[k] = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (int'(rr_reg) + k) % N_SRC;
            if (src_valid[idx] && (n_acc < int'(free))) begin
                grant[idx] = 1'b1;
                if (byp_allowed && n_acc == 0) begin
                    byp     = 1'b1;
                    byp_src = RW'(idx);
                end else begin
                    push_src[n_p] = RW'(idx);
                    n_p = n_p + 1;
                end
                n_acc   = n_acc + 1;
                rr_next = RW'((idx + 1) % N_SRC);
            end
        end
        n_push = CW'(n_p);
    end

    assign src_ready = rst ? '0 : grant;
    assign pending   = count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            rr_reg    <= '0;
            kill_reg  <= '0;
        end else begin
            if (pop) head_reg <= head_reg + AW'(1);
            tail_reg  <= tail_reg + AW'(n_push);
            count_reg <= count_reg - CW'(pop) + n_push;
            rr_reg    <= rr_next;
            kill_reg  <= kill_reg | squash_hit;
            // Newly written slots take the incoming kill, overriding any stale squash above.
            for (int j = 0; j < N_SRC; j++) begin
                if (CW'(j) < n_push)
                    kill_reg[tail_reg + AW'(j)] <= in_kill[push_src[j]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < N_SRC; j++) begin
            if (CW'(j) < n_push) begin
                rd_mem[tail_reg + AW'(j)]   <= in_rd[push_src[j]];
                data_mem[tail_reg + AW'(j)] <= in_data[push_src[j]];
                ctx_mem[tail_reg + AW'(j)]  <= in_ctx[push_src[j]];
            end
        end
    end

    // A hazard that arrives while the head pops still squashes it; only the output register is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_order <= 1'b0;
            w_pa_rd <= '0;
            w_d_rd  <= '0;
        end else if (pop) begin
            w_order <= ~(kill_reg[head_reg] | squash_hit[head_reg]) & (rd_mem[head_reg] != '0);
            w_pa_rd <= rd_mem[head_reg];
            w_d_rd  <= data_mem[head_reg];
        end else if (byp) begin
            w_order <= ~in_kill[byp_src] & (in_rd[byp_src] != '0);
            w_pa_rd <= in_rd[byp_src];
            w_d_rd  <= in_data[byp_src];
        end else begin
            w_order <= 1'b0;
        end
    end
endmodule

// File: tb/tb_write_back_queue.sv
// Randomized bench for write_back_queue against a queue-based reference model.
module tb_write_back_queue;
    localparam int N_SRC = 2;
    localparam int DEPTH = 8;
    localparam int LW    = 32;
    localparam int LA    = 6;
    localparam int LC    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N_SRC-1:0]    src_valid;
    logic [N_SRC-1:0]    src_ready;
    logic [N_SRC*LA-1:0] src_rd;
    logic [N_SRC*LW-1:0] src_data;
    logic [N_SRC*LC-1:0] src_ctx;
    logic                branch_hazard;
    logic [LC-1:0]       hazard_context_info;
    logic                w_order;
    logic [LA-1:0]       w_pa_rd;
    logic [LW-1:0]       w_d_rd;
    logic [$clog2(DEPTH):0] pending;

    write_back_queue #(.N_SRC(N_SRC), .DEPTH(DEPTH), .LEN_WORD(LW),
                       .LEN_PREG_ADDR(LA), .LEN_CONTEXT(LC)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_rd(src_rd), .src_data(src_data), .src_ctx(src_ctx),
        .branch_hazard(branch_hazard), .hazard_context_info(hazard_context_info),
        .w_order(w_order), .w_pa_rd(w_pa_rd), .w_d_rd(w_d_rd), .pending(pending)
    );

    always #5 clk = ~clk;

    logic [LA-1:0] t_rd   [N_SRC];
    logic [LW-1:0] t_data [N_SRC];
    logic [LC-1:0] t_ctx  [N_SRC];

    always_comb begin
        src_rd   = '0;
        src_data = '0;
        src_ctx  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            src_rd[i*LA +: LA]   = t_rd[i];
            src_data[i*LW +: LW] = t_data[i];
            src_ctx[i*LC +: LC]  = t_ctx[i];
        end
    end

    typedef struct {
        logic [LA-1:0] rd;
        logic [LW-1:0] data;
        logic [LC-1:0] ctx;
        bit            kill;
    } ent_t;

    ent_t q[$];
    int   rr;
    logic m_wo;
    logic [LA-1:0] m_rd;
    logic [LW-1:0] m_d;
    int total = 0;
    int bad   = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rr   = 0;
        m_wo = 1'b0;
        m_rd = '0;
        m_d  = '0;
    endtask

    // One clock: starts just after a negedge with inputs applied, ends at the next negedge.
    task automatic step();
        logic [N_SRC-1:0] exp_ready;
        int   acc[$];
        ent_t nq[$];
        ent_t e;
        int   cnt;
        int   free;
        cnt  = q.size();
        free = DEPTH - cnt + ((cnt > 0) ? 1 : 0);
        exp_ready = '0;
        for (int k = 0; k < N_SRC; k++) begin
            int i;
            i = (rr + k) % N_SRC;
            if (src_valid[i] && acc.size() < free) begin
                exp_ready[i] = 1'b1;
                acc.push_back(i);
            end
        end
        #1;
        check("ready", 64'(src_ready), 64'(exp_ready));

        if (branch_hazard)
            foreach (q[j]) if ((q[j].ctx & hazard_context_info) != 0) q[j].kill = 1'b1;
        foreach (acc[j]) begin
            e.rd   = t_rd[acc[j]];
            e.data = t_data[acc[j]];
            e.ctx  = t_ctx[acc[j]];
            e.kill = branch_hazard && ((e.ctx & hazard_context_info) != 0);
            nq.push_back(e);
        end
        if (cnt > 0) begin
            e = q.pop_front();
            m_wo = !e.kill && (e.rd != 0); m_rd = e.rd; m_d = e.data;
        end else if (BYP && nq.size() > 0) begin
            e = nq.pop_front();
            m_wo = !e.kill && (e.rd != 0); m_rd = e.rd; m_d = e.data;
        end else begin
            m_wo = 1'b0;
        end
        foreach (nq[j]) q.push_back(nq[j]);
        if (acc.size() > 0) rr = (acc[acc.size()-1] + 1) % N_SRC;

        @(posedge clk);
        #1;
        check("w_order", 64'(w_order), 64'(m_wo));
        check("w_pa_rd", 64'(w_pa_rd), 64'(m_rd));
        check("w_d_rd",  64'(w_d_rd),  64'(m_d));
        check("pending", 64'(pending), 64'(q.size()));
        if (w_order) $display("wb rd=%0d data=%08h pending=%0d", w_pa_rd, w_d_rd, pending);
        foreach (acc[j]) src_valid[acc[j]] = 1'b0;
        @(negedge clk);
        branch_hazard = 1'b0;
    endtask

    task automatic set_src(input int i, input logic [LA-1:0] rd, input logic [LW-1:0] d,
                           input logic [LC-1:0] c);
        src_valid[i] = 1'b1;
        t_rd[i] = rd; t_data[i] = d; t_ctx[i] = c;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        src_valid = '0;
        branch_hazard = 1'b0;
        hazard_context_info = '0;
        for (int i = 0; i < N_SRC; i++) begin
            t_rd[i] = '0; t_data[i] = '0; t_ctx[i] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(src_ready), 64'(0));
        rst = 1'b0;
        #1;
        check("rst_w_order", 64'(w_order), 64'(0));
        check("rst_w_pa_rd", 64'(w_pa_rd), 64'(0));
        check("rst_w_d_rd",  64'(w_d_rd),  64'(0));
        check("rst_pending", 64'(pending), 64'(0));
        @(negedge clk);

        // single write
        set_src(0, 6'd5, 32'hDEADBEEF, 4'b0001);
        step();
        idle(3);
        // simultaneous sources, same destination
        set_src(0, 6'd3, 32'hAAAA_0001, 4'b0001);
        set_src(1, 6'd3, 32'hBBBB_0002, 4'b0001);
        step();
        idle(3);
        // squash: rd7 ctx 0010 killed, rd8 ctx 0001 survives
        set_src(0, 6'd7, 32'h0000_0007, 4'b0010);
        set_src(1, 6'd8, 32'h0000_0008, 4'b0001);
        step();
        branch_hazard = 1'b1;
        hazard_context_info = 4'b0010;
        step();
        idle(3);
        // rd = 0 never writes
        set_src(1, 6'd0, 32'h0000_1234, 4'b0100);
        step();
        idle(2);

        // random traffic, mostly saturating
        for (int c = 0; c < 1500; c++) begin
            int rate;
            rate = (c < 1000) ? 4 : 1;
            for (int i = 0; i < N_SRC; i++) begin
                if (!src_valid[i] && ($urandom % 5) < rate)
                    set_src(i, LA'($urandom % 8), $urandom, LC'(1 << ($urandom % LC)));
            end
            branch_hazard = ($urandom % 8) == 0;
            hazard_context_info = LC'($urandom);
            step();
        end

        // reset in the middle of traffic
        src_valid = '0;
        idle(DEPTH + 2);
        set_src(0, 6'd9,  32'h9, 4'b0001);
        set_src(1, 6'd10, 32'hA, 4'b0001);
        step();
        set_src(0, 6'd11, 32'hB, 4'b0001);
        set_src(1, 6'd12, 32'hC, 4'b0001);
        step();
        set_src(0, 6'd13, 32'hD, 4'b0001);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_w_order", 64'(w_order), 64'(0));
        check("midrst_pending", 64'(pending), 64'(0));
        check("midrst_ready",   64'(src_ready), 64'(0));
        src_valid = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
